// File: rtl/addr_vec_fifo_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : addr_vec_fifo_if                                                |
// | Brief    : Producer/consumer bundle for the multi-port address FIFO.       |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface addr_vec_fifo_if #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_PORTS  = 16,
  parameter int FIFO_DEPTH = 16
);
  localparam int c_data_w = ADDR_WIDTH * NUM_PORTS;
  localparam int c_cnt_w  = $clog2(FIFO_DEPTH) + 1;

  logic                flush_i;
  logic                push_i;
  logic [c_data_w-1:0] addr_in_i;
  logic                pop_i;
  logic [c_data_w-1:0] addr_out_o;
  logic                valid_o;
  logic                empty_o;
  logic                full_o;
  logic                almost_full_o;
  logic                almost_empty_o;
  logic [c_cnt_w-1:0]  count_o;
  logic                overflow_o;
  logic                underflow_o;

  modport master (
    output flush_i, push_i, addr_in_i, pop_i,
    input  addr_out_o, valid_o, empty_o, full_o, almost_full_o,
    input  almost_empty_o, count_o, overflow_o, underflow_o
  );

  modport slave (
    input  flush_i, push_i, addr_in_i, pop_i,
    output addr_out_o, valid_o, empty_o, full_o, almost_full_o,
    output almost_empty_o, count_o, overflow_o, underflow_o
  );
endinterface
`default_nettype wire

// File: rtl/addr_vec_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : addr_vec_fifo                                                   |
// | Brief    : FIFO of NUM_PORTS-wide address vectors, registered or FWFT out. |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module addr_vec_fifo #(
  parameter int ADDR_WIDTH = 5,
  parameter int NUM_PORTS  = 16,
  parameter int FIFO_DEPTH = 16,
  parameter int FWFT       = 0,
  parameter int AF_THRESH  = FIFO_DEPTH - 2,
  parameter int AE_THRESH  = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  addr_vec_fifo_if.slave  bus
);
  localparam int c_data_w = ADDR_WIDTH * NUM_PORTS;
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_cnt_w  = c_ptr_w + 1;

  localparam logic [c_cnt_w-1:0] c_depth = c_cnt_w'(FIFO_DEPTH);
  localparam logic [c_cnt_w-1:0] c_af    = c_cnt_w'(AF_THRESH);
  localparam logic [c_cnt_w-1:0] c_ae    = c_cnt_w'(AE_THRESH);

  logic [c_data_w-1:0] r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]  r_wr_ptr;
  logic [c_ptr_w-1:0]  r_rd_ptr;
  logic [c_cnt_w-1:0]  r_count;
  logic                r_overflow;
  logic                r_underflow;

  logic w_empty;
  logic w_full;
  logic w_pop_acc;
  logic w_push_acc;

  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == c_depth);
  assign w_pop_acc  = bus.pop_i & ~w_empty;
  // A pop in the same cycle frees a slot, so a full FIFO still takes the push.
  assign w_push_acc = bus.push_i & (~w_full | w_pop_acc);

  // Storage is deliberately left out of reset and flush.
  always_ff @(posedge clk_i) begin
    if (w_push_acc && !bus.flush_i) begin
      r_mem[r_wr_ptr] <= bus.addr_in_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else if (bus.flush_i) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_push_acc) begin
        r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop_acc) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      case ({w_push_acc, w_pop_acc})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
      if (bus.push_i && !w_push_acc) begin
        r_overflow <= 1'b1;
      end
      if (bus.pop_i && !w_pop_acc) begin
        r_underflow <= 1'b1;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented as soon as the FIFO is non-empty.
      assign bus.addr_out_o = w_empty ? '0 : r_mem[r_rd_ptr];
      assign bus.valid_o    = ~w_empty;
    end else begin : g_reg
      logic [c_data_w-1:0] r_addr_out;
      logic                r_valid;

      always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
          r_addr_out <= '0;
          r_valid    <= 1'b0;
        end else if (bus.flush_i) begin
          r_addr_out <= '0;
          r_valid    <= 1'b0;
        end else begin
          r_valid <= w_pop_acc;
          if (w_pop_acc) begin
            r_addr_out <= r_mem[r_rd_ptr];
          end
        end
      end

      assign bus.addr_out_o = r_addr_out;
      assign bus.valid_o    = r_valid;
    end
  endgenerate

  assign bus.empty_o        = w_empty;
  assign bus.full_o         = w_full;
  assign bus.almost_full_o  = (r_count >= c_af);
  assign bus.almost_empty_o = (r_count <= c_ae);
  assign bus.count_o        = r_count;
  assign bus.overflow_o     = r_overflow;
  assign bus.underflow_o    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_addr_vec_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_addr_vec_fifo                                                |
// | Brief    : Registered and FWFT instances run side by side vs a queue model.|
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_addr_vec_fifo;
  localparam int AW = 5;
  localparam int NP = 16;
  localparam int D  = 16;
  localparam int AF = 14;
  localparam int AE = 1;
  localparam int DW = AW * NP;
  localparam int CW = $clog2(D) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  addr_vec_fifo_if #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .FIFO_DEPTH(D)) u_if0 ();
  addr_vec_fifo_if #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .FIFO_DEPTH(D)) u_if1 ();

  addr_vec_fifo #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .FIFO_DEPTH(D), .FWFT(0),
                  .AF_THRESH(AF), .AE_THRESH(AE))
    u_dut0 (.clk_i(clk), .rst_ni(rst_n), .bus(u_if0.slave));
  addr_vec_fifo #(.ADDR_WIDTH(AW), .NUM_PORTS(NP), .FIFO_DEPTH(D), .FWFT(1),
                  .AF_THRESH(AF), .AE_THRESH(AE))
    u_dut1 (.clk_i(clk), .rst_ni(rst_n), .bus(u_if1.slave));

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue of vectors plus the sticky flags and last pop.
  logic [DW-1:0] mq[$];
  bit            m_ovf, m_unf, m_val0;
  logic [DW-1:0] m_out0;

  function automatic logic [DW-1:0] make_vec(input int i);
    logic [DW-1:0] v;
    for (int p = 0; p < NP; p++) v[p*AW +: AW] = AW'(p + i);
    return v;
  endfunction

  task automatic model_reset();
    mq.delete();
    m_ovf = 0; m_unf = 0; m_val0 = 0; m_out0 = '0;
  endtask

  task automatic drive(input bit push, input bit pop, input bit flush, input logic [DW-1:0] din);
    u_if0.push_i = push; u_if0.pop_i = pop; u_if0.flush_i = flush; u_if0.addr_in_i = din;
    u_if1.push_i = push; u_if1.pop_i = pop; u_if1.flush_i = flush; u_if1.addr_in_i = din;
  endtask

  task automatic cycle(input bit push, input bit pop, input bit flush, input logic [DW-1:0] din);
    bit pa, qa;
    drive(push, pop, flush, din);
    @(posedge clk);
    if (flush) begin
      model_reset();
    end else begin
      pa = pop && (mq.size() > 0);
      qa = push && ((mq.size() < D) || pa);
      m_val0 = pa;
      if (pa) m_out0 = mq.pop_front();
      if (qa) mq.push_back(din);
      if (push && !qa) m_ovf = 1;
      if (pop && !pa) m_unf = 1;
    end
    #1;
    n_vec++;
    drive(0, 0, 0, '0);
  endtask

  task automatic test_reset();
    if ({u_if0.empty_o, u_if0.full_o, u_if0.almost_empty_o, u_if0.almost_full_o,
         u_if0.overflow_o, u_if0.underflow_o, u_if0.valid_o} !== 7'b1010000) begin
      $display("FAIL reset_status0 got %b want 1010000", {u_if0.empty_o, u_if0.full_o,
               u_if0.almost_empty_o, u_if0.almost_full_o, u_if0.overflow_o, u_if0.underflow_o, u_if0.valid_o});
      n_err++;
    end
    if (u_if0.count_o !== '0 || u_if0.addr_out_o !== '0) begin
      $display("FAIL reset_data0 count %0d out %h want 0/0", u_if0.count_o, u_if0.addr_out_o);
      n_err++;
    end
    if (u_if1.valid_o !== 1'b0 || u_if1.addr_out_o !== '0 || u_if1.empty_o !== 1'b1) begin
      $display("FAIL reset_fwft valid %b out %h empty %b", u_if1.valid_o, u_if1.addr_out_o, u_if1.empty_o);
      n_err++;
    end
  endtask

  task automatic test_fill();
    for (int i = 0; i < D; i++) begin
      cycle(1, 0, 0, make_vec(i));
      if (u_if0.count_o !== CW'(i + 1)) begin
        $display("FAIL fill_count got %0d want %0d", u_if0.count_o, i + 1); n_err++;
      end
      if (u_if0.almost_full_o !== (i + 1 >= AF) || u_if0.almost_empty_o !== (i + 1 <= AE)) begin
        $display("FAIL fill_thresh cnt %0d af %b ae %b", i + 1, u_if0.almost_full_o, u_if0.almost_empty_o);
        n_err++;
      end
    end
    if (u_if0.full_o !== 1'b1 || u_if1.addr_out_o !== make_vec(0) || u_if1.valid_o !== 1'b1) begin
      $display("FAIL fill_full full %b fwft_out %h want %h", u_if0.full_o, u_if1.addr_out_o, make_vec(0));
      n_err++;
    end
    cycle(1, 0, 0, make_vec(99));
    if (u_if0.overflow_o !== 1'b1 || u_if1.overflow_o !== 1'b1 || u_if0.count_o !== CW'(D)) begin
      $display("FAIL overflow ovf %b/%b count %0d want 1/1/%0d", u_if0.overflow_o, u_if1.overflow_o,
               u_if0.count_o, D);
      n_err++;
    end
  endtask

  task automatic test_drain();
    for (int i = 0; i < D; i++) begin
      cycle(0, 1, 0, '0);
      if (u_if0.addr_out_o !== make_vec(i) || u_if0.valid_o !== 1'b1) begin
        $display("FAIL drain_pop%0d got %h v%b want %h v1", i, u_if0.addr_out_o, u_if0.valid_o, make_vec(i));
        n_err++;
      end
      if (u_if0.almost_empty_o !== (D - 1 - i <= AE) || u_if0.count_o !== CW'(D - 1 - i)) begin
        $display("FAIL drain_ae cnt %0d ae %b", u_if0.count_o, u_if0.almost_empty_o); n_err++;
      end
      if (u_if1.addr_out_o !== ((i < D - 1) ? make_vec(i + 1) : '0)) begin
        $display("FAIL drain_fwft_head got %h", u_if1.addr_out_o); n_err++;
      end
      cycle(0, 0, 0, '0);
      if (u_if0.valid_o !== 1'b0 || u_if0.addr_out_o !== make_vec(i)) begin
        $display("FAIL drain_hold%0d got %h v%b want %h v0", i, u_if0.addr_out_o, u_if0.valid_o, make_vec(i));
        n_err++;
      end
    end
    cycle(0, 1, 0, '0);
    if (u_if0.empty_o !== 1'b1 || u_if0.underflow_o !== 1'b1 || u_if1.underflow_o !== 1'b1 ||
        u_if0.valid_o !== 1'b0 || u_if0.addr_out_o !== make_vec(D - 1)) begin
      $display("FAIL underflow empty %b unf %b/%b valid %b out %h want 1/1/1/0/%h", u_if0.empty_o,
               u_if0.underflow_o, u_if1.underflow_o, u_if0.valid_o, u_if0.addr_out_o, make_vec(D - 1));
      n_err++;
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] e0, e1;
    cycle(0, 0, 1, '0);
    for (int i = 0; i < D; i++) cycle(1, 0, 0, make_vec(100 + i));
    for (int k = 0; k < 20; k++) begin
      cycle(1, 1, 0, make_vec(200 + k));
      e0 = (k < D) ? make_vec(100 + k) : make_vec(200 + k - D);
      e1 = (k + 1 < D) ? make_vec(101 + k) : make_vec(201 + k - D);
      if (u_if0.count_o !== CW'(D) || u_if0.overflow_o !== 1'b0 || u_if0.full_o !== 1'b1) begin
        $display("FAIL b2b_status cnt %0d ovf %b full %b", u_if0.count_o, u_if0.overflow_o, u_if0.full_o);
        n_err++;
      end
      if (u_if0.addr_out_o !== e0 || u_if0.valid_o !== 1'b1 || u_if1.addr_out_o !== e1) begin
        $display("FAIL b2b_data%0d got %h/%h want %h/%h", k, u_if0.addr_out_o, u_if1.addr_out_o, e0, e1);
        n_err++;
      end
    end
  endtask

  task automatic test_fwft();
    cycle(0, 0, 1, '0);
    cycle(0, 1, 0, '0);
    if (u_if1.valid_o !== 1'b0 || u_if1.addr_out_o !== '0) begin
      $display("FAIL fwft_empty_pop valid %b out %h want 0/0", u_if1.valid_o, u_if1.addr_out_o); n_err++;
    end
    cycle(1, 0, 0, make_vec(7));
    if (u_if1.valid_o !== 1'b1 || u_if1.addr_out_o !== make_vec(7) || u_if0.valid_o !== 1'b0) begin
      $display("FAIL fwft_latency valid %b out %h reg_valid %b want 1/%h/0", u_if1.valid_o,
               u_if1.addr_out_o, u_if0.valid_o, make_vec(7));
      n_err++;
    end
  endtask

  task automatic test_flush();
    cycle(0, 0, 1, '0);
    for (int i = 0; i <= D; i++) cycle(1, 0, 0, make_vec(300 + i));
    for (int i = 0; i < D - 5; i++) cycle(0, 1, 0, '0);
    if (u_if0.count_o !== CW'(5) || u_if0.overflow_o !== 1'b1) begin
      $display("FAIL flush_pre cnt %0d ovf %b want 5/1", u_if0.count_o, u_if0.overflow_o); n_err++;
    end
    cycle(1, 0, 1, make_vec(50));
    if (u_if0.count_o !== '0 || u_if0.overflow_o !== 1'b0 || u_if0.valid_o !== 1'b0 ||
        u_if0.addr_out_o !== '0 || u_if0.empty_o !== 1'b1) begin
      $display("FAIL flush cnt %0d ovf %b valid %b out %h empty %b", u_if0.count_o, u_if0.overflow_o,
               u_if0.valid_o, u_if0.addr_out_o, u_if0.empty_o);
      n_err++;
    end
    cycle(0, 0, 0, '0);
    if (u_if0.count_o !== '0 || u_if1.valid_o !== 1'b0) begin
      $display("FAIL flush_discard cnt %0d fwft_valid %b want 0/0", u_if0.count_o, u_if1.valid_o); n_err++;
    end
  endtask

  task automatic test_random();
    bit push, pop, flush;
    int bias;
    logic [DW-1:0] h;
    for (int i = 0; i < 400; i++) begin
      bias  = (i / 50) % 2 ? 30 : 70;
      push  = ($urandom_range(0, 99) < bias);
      pop   = ($urandom_range(0, 99) >= bias);
      if ($urandom_range(0, 3) == 0) pop = push;
      flush = ($urandom_range(0, 79) == 0);
      cycle(push, pop, flush, DW'({$urandom, $urandom, $urandom}));
      if (u_if0.count_o !== CW'(mq.size()) || u_if1.count_o !== CW'(mq.size()) ||
          u_if0.empty_o !== (mq.size() == 0) || u_if0.full_o !== (mq.size() == D) ||
          u_if0.almost_full_o !== (mq.size() >= AF) || u_if0.almost_empty_o !== (mq.size() <= AE) ||
          u_if0.overflow_o !== m_ovf || u_if0.underflow_o !== m_unf ||
          u_if1.overflow_o !== m_ovf || u_if1.underflow_o !== m_unf) begin
        $display("FAIL rand_status%0d cnt %0d/%0d ovf %b unf %b want cnt %0d ovf %b unf %b", i,
                 u_if0.count_o, u_if1.count_o, u_if0.overflow_o, u_if0.underflow_o, mq.size(), m_ovf, m_unf);
        n_err++;
      end
      if (u_if0.valid_o !== m_val0 || u_if0.addr_out_o !== m_out0) begin
        $display("FAIL rand_reg%0d got %h v%b want %h v%b", i, u_if0.addr_out_o, u_if0.valid_o, m_out0, m_val0);
        n_err++;
      end
      h = (mq.size() > 0) ? mq[0] : '0;
      if (u_if1.valid_o !== (mq.size() > 0) || u_if1.addr_out_o !== h) begin
        $display("FAIL rand_fwft%0d got %h v%b want %h", i, u_if1.addr_out_o, u_if1.valid_o, h);
        n_err++;
      end
    end
  endtask

  task automatic test_async_reset();
    cycle(0, 0, 1, '0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 0, make_vec(400 + i));
    cycle(1, 1, 0, make_vec(410));
    cycle(0, 1, 0, '0);
    drive(1, 1, 0, make_vec(411));
    #2 rst_n = 1'b0;
    #1;
    if (u_if0.count_o !== '0 || u_if0.valid_o !== 1'b0 || u_if0.addr_out_o !== '0 ||
        u_if0.empty_o !== 1'b1 || u_if0.almost_empty_o !== 1'b1 || u_if1.valid_o !== 1'b0 ||
        u_if1.addr_out_o !== '0) begin
      $display("FAIL async_reset cnt %0d valid %b out %h empty %b fwft %b/%h", u_if0.count_o,
               u_if0.valid_o, u_if0.addr_out_o, u_if0.empty_o, u_if1.valid_o, u_if1.addr_out_o);
      n_err++;
    end
    drive(0, 0, 0, '0);
    model_reset();
    #10 rst_n = 1'b1;
    cycle(1, 0, 0, make_vec(500));
    if (u_if0.count_o !== CW'(1) || u_if1.addr_out_o !== make_vec(500)) begin
      $display("FAIL post_reset_push cnt %0d out %h want 1/%h", u_if0.count_o, u_if1.addr_out_o, make_vec(500));
      n_err++;
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, '0);
    model_reset();
    #23;
    test_reset();
    rst_n = 1'b1;
    #10;
    test_fill();
    test_drain();
    test_back_to_back();
    test_fwft();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
